fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Upstream of the fetch stage and feeding decode.
- Owns the program counter and drives `pc`/`order` into the fetch stage.
- Captures `inst` when `fetched` is high and presents instruction plus PC to decode over a valid/ready handshake.
- Handles branch/jump redirects from execute, squashing any in-flight or buffered instruction.

Parameters:
- RESET_PC, 0, PC value loaded on reset; must be 4-byte aligned.
- PC_STEP, 4, byte increment per sequential instruction.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- redirect  in  1  execute requests a PC change this cycle.
- redirect_pc  in  `LEN_MEM_ADDR  target PC for redirect.
- f_pc  out  `LEN_MEM_ADDR  PC presented to fetch (its `pc`).
- f_order  out  1  fetch request (its `order`).
- f_inst  in  `LEN_INST  instruction from fetch.
- f_fetched  in  1  fetch data valid this cycle.
- d_inst  out  `LEN_INST  instruction to decode.
- d_pc  out  `LEN_MEM_ADDR  PC of d_inst.
- d_valid  out  1  d_inst/d_pc valid.
- d_ready  in  1  decode accepts this cycle.

Behaviour:
- Reset (rstn low, async):
  - pc_r=RESET_PC, state=S_BOOT.
  - f_order=0, d_valid=0, d_inst=0, d_pc=0.
  - Reset mid-operation discards everything; no output glitches to nonzero.
- States:
  - S_BOOT: one cycle, f_order=0, then S_RUN.
  - S_RUN: normal operation.
  - No other states.
- f_pc = pc_r at all times.
- Output register free: slot_free = !d_valid || d_ready.
- f_order (combinational): state==S_RUN && slot_free && !redirect.
- Fetch contract: f_pc is held stable while f_order is high; dropping f_order cancels the request and fetch may drop any pending data.
- Capture on f_order && f_fetched:
  - d_inst<=f_inst, d_pc<=pc_r, d_valid<=1.
  - pc_r<=pc_r+PC_STEP, truncated to `LEN_MEM_ADDR (wraps to 0 at the top of the space).
- Throughput and latency:
  - With a zero-latency fetch (fetched=1 same cycle), one instruction per cycle.
  - Latency from f_order to d_valid is 1 cycle after f_fetched.
- Accept without new capture: when d_ready && d_valid and no capture occurs, d_valid<=0.
- Stall: d_valid && !d_ready → f_order=0, d_* held unchanged, pc_r unchanged.
- Redirect (highest priority, any state except S_BOOT):
  - pc_r<=redirect_pc with bits [1:0] forced to 0.
  - d_valid<=0 (buffered instruction squashed even if d_ready is high).
  - f_fetched in the same cycle is ignored.
  - The next cycle fetches redirect_pc.
- Redirect during S_BOOT: target still latched; state advances to S_RUN as normal.
- Redirect in consecutive cycles: the last one wins.
- d_inst/d_pc are don't-care-stable when d_valid=0: hold the last value, never X after reset.

Optional Feature:
- FETCH_SEQ_PERF_EN defined:
  - Adds outputs perf_fetched (32) and perf_bubble (32), both reset to 0.
  - perf_fetched increments on each capture.
  - perf_bubble increments each S_RUN cycle in which d_valid=0 and d_ready=1.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
- Shared header include.vh: `LEN_MEM_ADDR, `LEN_INST (existing); add `FSEQ_S_BOOT/`FSEQ_S_RUN state encodings (1 bit).
- One natural sub-module: fseq_out_reg, the d_inst/d_pc/d_valid output register with load/clear/hold controls.
- PC logic and FSM stay in the top.

Test Plan:
- Reset with RESET_PC=0, zero-latency fetch, d_ready=1:
  - f_order=0 in the boot cycle.
  - Then d_pc sequence 0,4,8,12 on consecutive cycles, d_inst matching the memory model.
- d_ready=0 for 3 cycles while d_valid=1 at d_pc=8:
  - f_order=0, d_pc stays 8, pc_r stays 12.
  - On release, the next d_pc is 12.
- Fetch latency 2 cycles:
  - f_pc held at 16 with f_order=1 until f_fetched.
  - d_valid rises the cycle after; no duplicate or skipped PCs.
- redirect=1, redirect_pc=0x103 while d_valid=1 at d_pc=20 and f_fetched=1:
  - d_valid=0 next cycle; fetched data dropped.
  - Next delivered d_pc=0x100.
- pc_r at max aligned address (all ones with [1:0]=00) → next f_pc wraps to 0.
- Assert rstn=0 mid-stall and mid-redirect:
  - Outputs reset asynchronously.
  - After release, the boot cycle is followed by d_pc=RESET_PC.
  - With FETCH_SEQ_PERF_EN, perf counters read 0.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared widths, FSM encodings and PC helpers for the fetch sequencer.
// The LEN_* and FSEQ_S_* macros default here when no project header supplies them.
`ifndef LEN_MEM_ADDR
`define LEN_MEM_ADDR 32
`endif
`ifndef LEN_INST
`define LEN_INST 32
`endif
`ifndef FSEQ_S_BOOT
`define FSEQ_S_BOOT 1'b0
`endif
`ifndef FSEQ_S_RUN
`define FSEQ_S_RUN 1'b1
`endif

package fetch_sequencer_pkg;

    localparam int MEM_ADDR_W = `LEN_MEM_ADDR;
    localparam int INST_W     = `LEN_INST;

    localparam logic [0:0] S_BOOT = `FSEQ_S_BOOT;
    localparam logic [0:0] S_RUN  = `FSEQ_S_RUN;

    function automatic logic [MEM_ADDR_W-1:0] align_pc(input logic [MEM_ADDR_W-1:0] a);
        return a & ~MEM_ADDR_W'(3);
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_sequencer_out_reg.sv
// Decode-facing output register: load, clear and hold of d_inst/d_pc/d_valid.
module fseq_out_reg
    import fetch_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic                  clear,
    input  logic [INST_W-1:0]     inst_in,
    input  logic [MEM_ADDR_W-1:0] pc_in,
    output logic [INST_W-1:0]     inst,
    output logic [MEM_ADDR_W-1:0] pc,
    output logic                  valid
);

    logic [INST_W-1:0]     inst_q, inst_d;
    logic [MEM_ADDR_W-1:0] pc_q, pc_d;
    logic                  valid_q, valid_d;

    // Clear wins over load so a squash can never leave a stale valid behind.
    always_comb begin
        inst_d  = inst_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            inst_d  = inst_in;
            pc_d    = pc_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inst_q  <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign inst  = inst_q;
    assign pc    = pc_q;
    assign valid = valid_q;

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner between fetch and decode, with redirect squash and a one-entry output slot.
// Optional perf counters are built when FETCH_SEQ_PERF_EN is defined.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [MEM_ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned           PC_STEP  = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  redirect,
    input  logic [MEM_ADDR_W-1:0] redirect_pc,
    output logic [MEM_ADDR_W-1:0] f_pc,
    output logic                  f_order,
    input  logic [INST_W-1:0]     f_inst,
    input  logic                  f_fetched,
    output logic [INST_W-1:0]     d_inst,
    output logic [MEM_ADDR_W-1:0] d_pc,
    output logic                  d_valid,
    input  logic                  d_ready
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_bubble
`endif
);

    logic [0:0]            state_q, state_d;
    logic [MEM_ADDR_W-1:0] pc_q, pc_d;
    logic                  slot_free;
    logic                  capture;
    logic                  clear;

    // Redirect has priority over capture; a fetch completing in the same cycle is dropped.
    always_comb begin
        slot_free = !d_valid || d_ready;
        f_order   = (state_q == S_RUN) && slot_free && !redirect;
        capture   = f_order && f_fetched;
        clear     = redirect || (d_valid && d_ready && !capture);
        state_d   = S_RUN;
        pc_d      = pc_q;
        if (redirect) begin
            pc_d = align_pc(redirect_pc);
        end else if (capture) begin
            pc_d = pc_q + MEM_ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign f_pc = pc_q;

    fseq_out_reg u_out_reg (
        .clk     (clk),
        .rstn    (rstn),
        .load    (capture),
        .clear   (clear),
        .inst_in (f_inst),
        .pc_in   (pc_q),
        .inst    (d_inst),
        .pc      (d_pc),
        .valid   (d_valid)
    );

`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;

    always_comb begin
        perf_fetched_d = capture ? sat_inc32(perf_fetched_q) : perf_fetched_q;
        perf_bubble_d  = perf_bubble_q;
        if ((state_q == S_RUN) && !d_valid && d_ready) begin
            perf_bubble_d = sat_inc32(perf_bubble_q);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_fetched_q <= '0;
            perf_bubble_q  <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_bubble_q  <= perf_bubble_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubble  = perf_bubble_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed phases push expected (pc, inst) pairs,
// a negedge monitor pops them on every accepted decode transfer.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] pc;
        logic [INST_W-1:0]     inst;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  redirect;
    logic [MEM_ADDR_W-1:0] redirect_pc;
    logic [MEM_ADDR_W-1:0] f_pc;
    logic                  f_order;
    logic [INST_W-1:0]     f_inst;
    logic                  f_fetched;
    logic [INST_W-1:0]     d_inst;
    logic [MEM_ADDR_W-1:0] d_pc;
    logic                  d_valid;
    logic                  d_ready;
`ifdef FETCH_SEQ_PERF_EN
    logic [31:0]           perf_fetched;
    logic [31:0]           perf_bubble;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    logic fetch_en;
    int   lat;
    int   wait_cnt = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC('0), .PC_STEP(4)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .f_pc        (f_pc),
        .f_order     (f_order),
        .f_inst      (f_inst),
        .f_fetched   (f_fetched),
        .d_inst      (d_inst),
        .d_pc        (d_pc),
        .d_valid     (d_valid),
        .d_ready     (d_ready)
`ifdef FETCH_SEQ_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_bubble (perf_bubble)
`endif
    );

    function automatic logic [INST_W-1:0] mem(input logic [MEM_ADDR_W-1:0] a);
        logic [31:0] h;
        h = 32'(a) * 32'h9E37_79B1 ^ 32'h0BAD_F00D;
        return INST_W'(h);
    endfunction

    // Fetch model: latency 0 answers every cycle, otherwise after lat cycles of a held request.
    assign f_fetched = fetch_en && ((lat == 0) || (f_order && (wait_cnt >= lat)));
    assign f_inst    = f_fetched ? mem(f_pc) : INST_W'(32'hDEAD_BEEF);

    always @(posedge clk) begin
        if (f_order && !f_fetched) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [MEM_ADDR_W-1:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = mem(pc);
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_d_valid"}, 64'(d_valid), 64'd0);
        check({tag, "_d_pc"},    64'(d_pc),    64'd0);
        check({tag, "_d_inst"},  64'(d_inst),  64'd0);
        check({tag, "_f_order"}, 64'(f_order), 64'd0);
        check({tag, "_f_pc"},    64'(f_pc),    64'd0);
`ifdef FETCH_SEQ_PERF_EN
        check({tag, "_perf_fetched"}, 64'(perf_fetched), 64'd0);
        check({tag, "_perf_bubble"},  64'(perf_bubble),  64'd0);
`endif
    endtask

    // Monitor: a squashing redirect cycle is not a transfer.
    always @(negedge clk) begin
        if (rstn && d_valid && d_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                check("unexpected_transfer_pc", 64'(d_pc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_d_pc",   64'(d_pc),   64'(e.pc));
                check("sb_d_inst", 64'(d_inst), 64'(e.inst));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn        = 1'b0;
        d_ready     = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        fetch_en    = 1'b0;
        lat         = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");

        // Boot cycle, then 0,4,8 back to back.
        step(); rstn = 1'b1; fetch_en = 1'b1;
        push_exp('h0); push_exp('h4); push_exp('h8);
        @(negedge clk);
        check("boot_f_order", 64'(f_order), 64'd0);
        step();
        @(negedge clk);
        check("run_f_order", 64'(f_order), 64'd1);
        check("run_f_pc",    64'(f_pc),    64'd0);
        step(); step();
        step(); d_ready = 1'b0;

        // Three stalled cycles holding pc 8.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_f_order", 64'(f_order), 64'd0);
            check("stall_d_valid", 64'(d_valid), 64'd1);
            check("stall_d_pc",    64'(d_pc),    64'h8);
            check("stall_f_pc",    64'(f_pc),    64'hC);
            step();
        end
        d_ready = 1'b1;
        push_exp('hC);

        // Two-cycle fetch latency on pc 16.
        step(); lat = 2;
        push_exp('h10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lat_f_order", 64'(f_order), 64'd1);
            check("lat_f_pc",    64'(f_pc),    64'h10);
            if (i == 1) check("lat_d_valid", 64'(d_valid), 64'd0);
            step();
        end
        lat = 0;

        // Redirect while pc 20 is buffered and fetch data is present.
        step(); redirect = 1'b1; redirect_pc = 'h103;
        @(negedge clk);
        check("redir_f_order", 64'(f_order), 64'd0);
        step(); redirect = 1'b0;
        push_exp('h100);
        @(negedge clk);
        check("redir_d_valid", 64'(d_valid), 64'd0);
        check("redir_f_pc",    64'(f_pc),    64'h100);
        check("redir_f_order_next", 64'(f_order), 64'd1);
        step(); fetch_en = 1'b0;

        // Back-to-back redirects: the last target wins.
        step(); redirect = 1'b1; redirect_pc = 'h200;
        step(); redirect_pc = 'h300;
        step(); redirect = 1'b0; fetch_en = 1'b1;
        push_exp('h300);
        @(negedge clk);
        check("redir2_f_pc", 64'(f_pc), 64'h300);
        step(); fetch_en = 1'b0;

        // Top of the address space wraps to zero.
        step(); redirect = 1'b1; redirect_pc = '1;
        step(); redirect = 1'b0; fetch_en = 1'b1;
        push_exp(align_pc('1)); push_exp('h0);
        @(negedge clk);
        check("wrap_top_f_pc", 64'(f_pc), 64'(align_pc('1)));
        step();
        @(negedge clk);
        check("wrap_f_pc", 64'(f_pc), 64'h0);
        step(); fetch_en = 1'b0;

        // Reset in the middle of a stall.
        step(); fetch_en = 1'b1; d_ready = 1'b0;
        step(); fetch_en = 1'b0;
        #1;
        check("pre_rst_d_valid", 64'(d_valid), 64'd1);
        check("pre_rst_d_pc",    64'(d_pc),    64'h4);
        check("pre_rst_f_order", 64'(f_order), 64'd0);
        #1; rstn = 1'b0;
        #1;
        check_reset_outputs("rst_stall");
        check("rst_stall_queue", 64'(exp_q.size()), 64'd0);
        d_ready = 1'b1;
        step(); rstn = 1'b1; fetch_en = 1'b1;
        push_exp('h0);
        @(negedge clk);
        check("reboot1_f_order", 64'(f_order), 64'd0);
        step();
        step(); fetch_en = 1'b0;

        // Reset in the middle of a redirect.
        step(); redirect = 1'b1; redirect_pc = 'h40;
        #2; rstn = 1'b0;
        #1;
        check_reset_outputs("rst_redir");
        redirect = 1'b0;
        step(); rstn = 1'b1; fetch_en = 1'b1;
        push_exp('h0); push_exp('h4);
        @(negedge clk);
        check("reboot2_f_order", 64'(f_order), 64'd0);
        step(); step();
        step(); fetch_en = 1'b0;
`ifdef FETCH_SEQ_PERF_EN
        @(negedge clk);
        check("perf_fetched", 64'(perf_fetched), 64'd2);
        check("perf_bubble",  64'(perf_bubble),  64'd1);
`endif
        repeat (3) step();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
